gray_hist_stat: RTL
===================

Name: gray_hist_stat

Overview:
- Per-frame 256-bin grayscale histogram accumulator.
- Sits directly downstream of the median filter stage and consumes its post_img_vsync/href/gray stream. Histogram statistics (contrast stretch, thresholding) are computed on the filtered image.
- After frame end, a random-access readout port exposes the finished histogram to a downstream controller until it is released.

Parameters:
IMG_H_DISP, 640, active pixels per line (sizes counters only)
IMG_V_DISP, 480, active lines per frame
CNT_W, 19, bin/pixel counter width; must hold IMG_H_DISP*IMG_V_DISP

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
per_img_vsync  in  1  frame valid, high for whole frame (filter output)
per_img_href  in  1  pixel valid
per_img_gray  in  8  pixel value
hist_rd_en  in  1  readout request, honoured only while hist_ready=1
hist_rd_addr  in  8  bin index
hist_rd_data  out  CNT_W  bin count
hist_rd_valid  out  1  hist_rd_data valid, 1 cycle after accepted hist_rd_en
hist_rel  in  1  single-cycle pulse: readout finished, re-arm
hist_ready  out  1  histogram of last frame complete and readable
frame_pix_cnt  out  CNT_W  href pixels counted in last completed frame
frame_drop  out  1  1-cycle pulse: frame start seen while not armed

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (rst).
- Reset values: hist_rd_data=0, hist_rd_valid=0, hist_ready=0, frame_pix_cnt=0, frame_drop=0. The FSM enters CLEAR.
- Storage: 256 x CNT_W single-clock RAM, 1-cycle read latency, no reset on contents.
- FSM states:
  - CLEAR: write 0 to addr 0..255, one per cycle, 256 cycles, then go to ARM.
  - ARM: wait for vsync rising edge (registered vsync 0->1), then go to ACCUM and zero the pixel counter.
  - ACCUM: for each cycle with href=1, bin[gray] += 1 and pixel counter += 1. On vsync falling edge go to DRAIN.
  - DRAIN: 2 cycles to flush the RMW pipeline, then go to DONE. frame_pix_cnt latches the counter on DRAIN exit.
  - DONE: hist_ready=1 and reads are accepted. A hist_rel pulse goes to CLEAR; hist_ready drops the cycle after hist_rel.
- RMW pipeline: stage0 issues read at gray; stage1 has read data; stage2 writes data+1.
  - Forwarding is mandatory: if stage0 addr equals an in-flight stage1 or stage2 addr, use the forwarded count.
  - Back-to-back identical gray values (e.g. 640 pixels of 0x80) must give exact counts.
- Bin and pixel counters saturate at 2^CNT_W-1; they never wrap.
- href=1 while vsync=0 is ignored.
- An href pixel on the same cycle as vsync falling is still counted.
- A vsync rising edge in CLEAR, DRAIN or DONE: frame not accumulated, frame_drop pulses 1 cycle, and the histogram in DONE stays intact.
- A frame already in progress when ARM is entered (vsync already high) is ignored until the next rising edge.
- Readout:
  - hist_rd_en is ignored unless hist_ready=1.
  - hist_rd_en and hist_rel in the same cycle: the read is served (valid next cycle), then CLEAR.
  - hist_rd_data holds its last value when not valid.
- rst asserted mid-ACCUM or mid-DONE: the partial histogram is discarded, a full CLEAR runs, and hist_ready=0 within 1 cycle.

Optional Feature:
- Macro: HIST_CDF_EN
- Defined:
  - DRAIN is followed by a CUMSUM state: 256 cycles of in-place prefix sum, bin[i] = bin[i] + bin[i-1], using the same RMW pipeline with forwarding. Then go to DONE.
  - Reads return the cumulative count; bin 255 equals frame_pix_cnt.
  - DRAIN-to-hist_ready latency grows by 256+2 cycles.
- Not defined: reads return raw per-bin counts; there is no CUMSUM state.

Test Plan:
- Reset, then an 8x4 frame of constant gray 0x80 (IMG_H_DISP=8, IMG_V_DISP=4) -> bin 0x80=32, all other bins 0, frame_pix_cnt=32; with HIST_CDF_EN, bins 0..0x7F=0 and 0x80..0xFF=32.
- Ramp frame, gray = pixel index 0..255 over 256 pixels, back-to-back -> every bin=1. Alternating 0x10,0x10,0x11,0x10 -> bin 0x10=3, bin 0x11=1 (forwarding check).
- Second frame while in DONE (no hist_rel) -> frame_drop pulses once, bins still hold frame 1 values. After hist_rel plus 256 CLEAR cycles, the third frame is counted alone.
- hist_rd_en at addr 0x80 with hist_ready=0 -> hist_rd_valid stays 0. Same read in DONE -> hist_rd_valid=1 one cycle later with data 32.
- rst pulsed mid-ACCUM, then a clean 8x4 frame of gray 0x05 -> bin 0x05=32, bin 0x80=0, frame_pix_cnt=32.
- CNT_W=4 with 20 pixels of gray 0x01 -> bin 0x01=15 and frame_pix_cnt=15 (saturation, no wrap).

Source files
------------

// File: rtl/gray_hist_stat.sv
// gray_hist_stat: per-frame 256-bin grayscale histogram with random-access readout.
// Consumes the median-filter output stream and accumulates one histogram per
// accepted frame through a forwarded read-modify-write pipeline.
// Optional build macro HIST_CDF_EN: after each frame the bins are turned into a
// cumulative histogram in place (CUMSUM state) before the readout is opened.
module gray_hist_stat #(
    parameter int IMG_H_DISP = 640,
    parameter int IMG_V_DISP = 480,
    parameter int CNT_W      = $clog2(IMG_H_DISP * IMG_V_DISP + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             per_img_vsync,
    input  logic             per_img_href,
    input  logic [7:0]       per_img_gray,
    input  logic             hist_rd_en,
    input  logic [7:0]       hist_rd_addr,
    output logic [CNT_W-1:0] hist_rd_data,
    output logic             hist_rd_valid,
    input  logic             hist_rel,
    output logic             hist_ready,
    output logic [CNT_W-1:0] frame_pix_cnt,
    output logic             frame_drop
);

    typedef enum logic [2:0] {
        S_CLEAR, S_ARM, S_ACCUM, S_DRAIN, S_CUMSUM, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [8:0]       seq_cnt;
    logic             vsync_d, vs_rise, vs_fall;
    logic             clr_we, pix_go, cum_go, rd_accept, drop_det;
    logic [CNT_W-1:0] pix_cnt;

    logic [CNT_W-1:0] mem [256];
    logic [CNT_W-1:0] ram_q;
    logic             s0_valid;
    logic [7:0]       s0_addr;
    logic             s1_valid, s2_valid, s3_valid;
    logic [7:0]       s1_addr, s2_addr, s3_addr;
    logic [CNT_W-1:0] s2_data, s3_data;
    logic [CNT_W-1:0] s1_base, s1_addend, s1_sum;
    logic [CNT_W:0]   s1_wide;
    logic             wr_en;
    logic [7:0]       wr_addr;
    logic [CNT_W-1:0] wr_data;
`ifdef HIST_CDF_EN
    logic             s1_cum;
    logic [CNT_W-1:0] run_sum;
`endif

    assign vs_rise = per_img_vsync & ~vsync_d;
    assign vs_fall = ~per_img_vsync & vsync_d;

    // State register plus the vsync history used for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: every sequential assignment is non-blocking so all registers
        // update together from pre-edge values, independent of statement order.
        if (rst) begin
            state   <= S_CLEAR;
            vsync_d <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_d <= per_img_vsync;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_CLEAR:  if (seq_cnt == 9'd255) state_nxt = S_ARM;
            S_ARM:    if (vs_rise) state_nxt = S_ACCUM;
            S_ACCUM:  if (vs_fall) state_nxt = S_DRAIN;
`ifdef HIST_CDF_EN
            S_DRAIN:  if (seq_cnt == 9'd1) state_nxt = S_CUMSUM;
            S_CUMSUM: if (seq_cnt == 9'd257) state_nxt = S_DONE;
`else
            S_DRAIN:  if (seq_cnt == 9'd1) state_nxt = S_DONE;
`endif
            S_DONE:   if (hist_rel) state_nxt = S_CLEAR;
            default:  state_nxt = S_CLEAR;
        endcase
    end

    // Per-state control strobes; a pixel on the vsync falling cycle still counts.
    always_comb begin
        clr_we     = 1'b0;
        pix_go     = 1'b0;
        cum_go     = 1'b0;
        rd_accept  = 1'b0;
        hist_ready = 1'b0;
        case (state)
            S_CLEAR:  clr_we = 1'b1;
            S_ARM:    pix_go = vs_rise & per_img_href;
            S_ACCUM:  pix_go = per_img_href & (per_img_vsync | vs_fall);
            S_CUMSUM: cum_go = ~seq_cnt[8];
            S_DONE: begin
                hist_ready = 1'b1;
                rd_accept  = hist_rd_en;
            end
            default: ;
        endcase
        drop_det = vs_rise & (state inside {S_CLEAR, S_DRAIN, S_CUMSUM, S_DONE});
    end

    // Sequence counter for CLEAR / DRAIN / CUMSUM, restarted on every state change.
    always_ff @(posedge clk) begin
        if (rst || state_nxt != state) seq_cnt <= '0;
        else                           seq_cnt <= seq_cnt + 9'd1;
    end

    assign s0_valid = pix_go | cum_go;
    assign s0_addr  = cum_go ? seq_cnt[7:0] : per_img_gray;
    assign wr_en    = clr_we | s2_valid;
    assign wr_addr  = clr_we ? seq_cnt[7:0] : s2_addr;
    assign wr_data  = clr_we ? '0 : s2_data;

    // Bin RAM: one write port, one pipeline read port with 1-cycle latency.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; CLEAR zeroes it, which keeps it mappable to RAM.
        if (wr_en)    mem[wr_addr] <= wr_data;
        if (s0_valid) ram_q        <= mem[s0_addr];
    end

    // Readout port: registered data that holds between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_rd_data  <= '0;
            hist_rd_valid <= 1'b0;
        end else begin
            hist_rd_valid <= rd_accept;
            if (rd_accept) hist_rd_data <= mem[hist_rd_addr];
        end
    end

    // Stage1 operand: the RAM word may be stale if the same bin is being written
    // now (stage2) or was written on the previous edge (stage3), so forward those.
    always_comb begin
        s1_base = ram_q;
        if (s2_valid && s2_addr == s1_addr)      s1_base = s2_data;
        else if (s3_valid && s3_addr == s1_addr) s1_base = s3_data;
        s1_addend = CNT_W'(1);
`ifdef HIST_CDF_EN
        if (s1_cum) s1_addend = run_sum;
`endif
        s1_wide = {1'b0, s1_base} + {1'b0, s1_addend};
        s1_sum  = s1_wide[CNT_W] ? CNT_MAX : s1_wide[CNT_W-1:0];
    end

    // RMW pipeline registers: stage1 (read data back), stage2 (write), stage3 (just written).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;  s1_addr <= '0;
            s2_valid <= 1'b0;  s2_addr <= '0;  s2_data <= '0;
            s3_valid <= 1'b0;  s3_addr <= '0;  s3_data <= '0;
        end else begin
            s1_valid <= s0_valid;  s1_addr <= s0_addr;
            s2_valid <= s1_valid;  s2_addr <= s1_addr;  s2_data <= s1_sum;
            s3_valid <= s2_valid;  s3_addr <= s2_addr;  s3_data <= s2_data;
        end
    end

`ifdef HIST_CDF_EN
    // Prefix-sum carry: running total of bins already accumulated this pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_cum  <= 1'b0;
            run_sum <= '0;
        end else begin
            s1_cum <= cum_go;
            if (state == S_DRAIN)       run_sum <= '0;
            else if (s1_valid && s1_cum) run_sum <= s1_sum;
        end
    end
`endif

    // Saturating pixel counter, frame result latch and drop pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt       <= '0;
            frame_pix_cnt <= '0;
            frame_drop    <= 1'b0;
        end else begin
            frame_drop <= drop_det;
            if (state == S_ARM && vs_rise)       pix_cnt <= CNT_W'(pix_go);
            else if (pix_go && pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + CNT_W'(1);
            if (state == S_DRAIN && seq_cnt == 9'd1) frame_pix_cnt <= pix_cnt;
        end
    end

endmodule
